// File: rtl/rv_csr_machine_trap_if.sv
// Port bundle between the execute stage and the machine-mode CSR/trap block.
// The core side drives CSR accesses, interrupt levels, exceptions and mret.
interface rv_csr_machine_trap_if #(
    parameter int NUM_LOCAL_IRQ = 0
);
    localparam int LOCAL_W = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1;

    logic               sel;
    logic [7:0]         idx;
    logic [31:0]        wdata;
    logic               write;
    logic               set;
    logic               clear;
    logic [31:0]        rdata;

    logic               irq_ext;
    logic               irq_timer;
    logic               irq_soft;
    logic [LOCAL_W-1:0] irq_local;
    logic [31:0]        irq_pc;
    logic               irq_ack;

    logic               exc_valid;
    logic [4:0]         exc_code;
    logic [31:0]        exc_pc;
    logic [31:0]        exc_tval;
    logic               mret;

    logic               irq_req;
    logic               trap_valid;
    logic [31:0]        trap_pc;
    logic [31:0]        ret_addr;

    modport master (
        output sel, idx, wdata, write, set, clear,
        output irq_ext, irq_timer, irq_soft, irq_local, irq_pc, irq_ack,
        output exc_valid, exc_code, exc_pc, exc_tval, mret,
        input  rdata, irq_req, trap_valid, trap_pc, ret_addr
    );

    modport slave (
        input  sel, idx, wdata, write, set, clear,
        input  irq_ext, irq_timer, irq_soft, irq_local, irq_pc, irq_ack,
        input  exc_valid, exc_code, exc_pc, exc_tval, mret,
        output rdata, irq_req, trap_valid, trap_pc, ret_addr
    );
endinterface

// File: rtl/rv_csr_machine_trap.sv
// Machine-mode CSR file with interrupt arbitration, request/ack handshake,
// trap entry for exceptions and interrupts, and mret trap exit.
module rv_csr_machine_trap #(
    parameter bit          EXTENSION_C   = 1'b1,
    parameter int          NUM_LOCAL_IRQ = 0,
    parameter bit          VECTORED_EN   = 1'b1,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000
) (
    input logic                   clk,
    input logic                   reset,
    rv_csr_machine_trap_if.slave  bus
);
    localparam logic [7:0] IDX_MSTATUS  = 8'h00;
    localparam logic [7:0] IDX_MISA     = 8'h01;
    localparam logic [7:0] IDX_MIE      = 8'h04;
    localparam logic [7:0] IDX_MTVEC    = 8'h05;
    localparam logic [7:0] IDX_MSCRATCH = 8'h40;
    localparam logic [7:0] IDX_MEPC     = 8'h41;
    localparam logic [7:0] IDX_MCAUSE   = 8'h42;
    localparam logic [7:0] IDX_MTVAL    = 8'h43;
    localparam logic [7:0] IDX_MIP      = 8'h44;

    // Wraps correctly to 32'hFFFF_0000 for 16 local lines.
    localparam logic [31:0] LOCAL_MASK = (32'h1 << (16 + NUM_LOCAL_IRQ)) - (32'h1 << 16);
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;
    localparam logic [31:0] MEPC_MASK  = EXTENSION_C ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
    localparam logic [31:0] MISA_VAL   = 32'h4000_0100 | (EXTENSION_C ? 32'h4 : 32'h0);

    typedef enum logic {RUN, REQ} state_t;

    state_t      state;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [4:0]  irq_code;
    logic        irq_req;
    logic        trap_valid;

    logic [31:0] mip;
    logic [31:0] pend;
    logic [4:0]  win_code;
    logic [31:0] csr_old;
    logic [31:0] csr_new;
    logic        csr_we;
    logic        mode_ok;
    logic [31:0] trap_base;
    logic        unused_irq_local;

    assign unused_irq_local = ^bus.irq_local;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mip     = '0;
        mip[11] = bus.irq_ext;
        mip[7]  = bus.irq_timer;
        mip[3]  = bus.irq_soft;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            mip[16 + i] = bus.irq_local[i];
        end
    end

    assign pend = mip & mie;

    // Later assignments override earlier ones, so the highest priority source is applied last.
    always_comb begin
        win_code = '0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            if (pend[16 + i]) win_code = 5'(16 + i);
        end
        if (pend[7])  win_code = 5'd7;
        if (pend[3])  win_code = 5'd3;
        if (pend[11]) win_code = 5'd11;
    end

    always_comb begin
        csr_old = '0;
        if (bus.sel) begin
            case (bus.idx)
                IDX_MSTATUS:  csr_old = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
                IDX_MISA:     csr_old = MISA_VAL;
                IDX_MIE:      csr_old = mie;
                IDX_MTVEC:    csr_old = mtvec;
                IDX_MSCRATCH: csr_old = mscratch;
                IDX_MEPC:     csr_old = mepc;
                IDX_MCAUSE:   csr_old = mcause;
                IDX_MTVAL:    csr_old = mtval;
                IDX_MIP:      csr_old = mip;
                default:      csr_old = '0;
            endcase
        end
    end

    always_comb begin
        csr_new = csr_old;
        if (bus.write)      csr_new = bus.wdata;
        else if (bus.set)   csr_new = csr_old | bus.wdata;
        else if (bus.clear) csr_new = csr_old & ~bus.wdata;
    end

    assign csr_we  = bus.sel & (bus.write | bus.set | bus.clear);
    assign mode_ok = (csr_new[1:0] == 2'b00) || (VECTORED_EN && csr_new[1:0] == 2'b01);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie          <= '0;
            mtvec        <= MTVEC_RESET;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
            irq_code     <= '0;
            irq_req      <= 1'b0;
            trap_valid   <= 1'b0;
        end else begin
            trap_valid <= 1'b0;

            // NOTE: the trap updates below are later non-blocking assignments, so they win over a same-cycle CSR write.
            if (csr_we) begin
                case (bus.idx)
                    IDX_MSTATUS: begin
                        mstatus_mie  <= csr_new[3];
                        mstatus_mpie <= csr_new[7];
                    end
                    IDX_MIE:      mie      <= csr_new & MIE_MASK;
                    IDX_MTVEC:    mtvec    <= {csr_new[31:2], mode_ok ? csr_new[1:0] : mtvec[1:0]};
                    IDX_MSCRATCH: mscratch <= csr_new;
                    IDX_MEPC:     mepc     <= csr_new & MEPC_MASK;
                    IDX_MCAUSE:   mcause   <= csr_new;
                    IDX_MTVAL:    mtval    <= csr_new;
                    default: ;
                endcase
            end

            if (bus.exc_valid) begin
                mepc         <= bus.exc_pc & MEPC_MASK;
                mcause       <= {27'b0, bus.exc_code};
                mtval        <= bus.exc_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
                trap_valid   <= 1'b1;
                irq_req      <= 1'b0;
                state        <= RUN;
            end else begin
                if (bus.mret) begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end
                case (state)
                    RUN: begin
                        if (mstatus_mie && |pend) begin
                            irq_code <= win_code;
                            irq_req  <= 1'b1;
                            state    <= REQ;
                        end
                    end
                    REQ: begin
                        if (bus.irq_ack) begin
                            mepc         <= bus.irq_pc & MEPC_MASK;
                            mcause       <= {1'b1, 26'b0, irq_code};
                            mstatus_mpie <= mstatus_mie;
                            mstatus_mie  <= 1'b0;
                            trap_valid   <= 1'b1;
                            irq_req      <= 1'b0;
                            state        <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    assign trap_base    = {mtvec[31:2], 2'b00};
    assign bus.trap_pc  = (mcause[31] && mtvec[1:0] == 2'b01)
                        ? trap_base + {25'b0, mcause[4:0], 2'b00}
                        : trap_base;
    assign bus.rdata      = csr_old;
    assign bus.irq_req    = irq_req;
    assign bus.trap_valid = trap_valid;
    assign bus.ret_addr   = mepc;
endmodule

// File: tb/tb_rv_csr_machine_trap.sv
// Directed bench: dut_a uses default parameters, dut_b has EXTENSION_C=0 and two local IRQs.
// dut_b mirrors every dut_a input except the local interrupt lines.
module tb_rv_csr_machine_trap;
    localparam int OP_WR = 0;
    localparam int OP_SET = 1;
    localparam int OP_CLR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] irq_local_b = 2'b00;
    int         vectors = 0;
    int         miscompares = 0;

    rv_csr_machine_trap_if #(.NUM_LOCAL_IRQ(0)) bus_a ();
    rv_csr_machine_trap_if #(.NUM_LOCAL_IRQ(2)) bus_b ();

    rv_csr_machine_trap dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    rv_csr_machine_trap #(.EXTENSION_C(1'b0), .NUM_LOCAL_IRQ(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    assign bus_b.sel       = bus_a.sel;
    assign bus_b.idx       = bus_a.idx;
    assign bus_b.wdata     = bus_a.wdata;
    assign bus_b.write     = bus_a.write;
    assign bus_b.set       = bus_a.set;
    assign bus_b.clear     = bus_a.clear;
    assign bus_b.irq_ext   = bus_a.irq_ext;
    assign bus_b.irq_timer = bus_a.irq_timer;
    assign bus_b.irq_soft  = bus_a.irq_soft;
    assign bus_b.irq_local = irq_local_b;
    assign bus_b.irq_pc    = bus_a.irq_pc;
    assign bus_b.irq_ack   = bus_a.irq_ack;
    assign bus_b.exc_valid = bus_a.exc_valid;
    assign bus_b.exc_code  = bus_a.exc_code;
    assign bus_b.exc_pc    = bus_a.exc_pc;
    assign bus_b.exc_tval  = bus_a.exc_tval;
    assign bus_b.mret      = bus_a.mret;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_op(input logic [7:0] idx, input logic [31:0] data, input int kind);
        bus_a.sel   = 1'b1;
        bus_a.idx   = idx;
        bus_a.wdata = data;
        bus_a.write = (kind == OP_WR);
        bus_a.set   = (kind == OP_SET);
        bus_a.clear = (kind == OP_CLR);
        step();
        bus_a.sel   = 1'b0;
        bus_a.write = 1'b0;
        bus_a.set   = 1'b0;
        bus_a.clear = 1'b0;
    endtask

    task automatic csr_rd(input bit use_b, input logic [7:0] idx, output logic [31:0] data);
        bus_a.sel = 1'b1;
        bus_a.idx = idx;
        #1;
        data = use_b ? bus_b.rdata : bus_a.rdata;
        bus_a.sel = 1'b0;
    endtask

    task automatic check_csr(input string tag, input bit use_b, input logic [7:0] idx,
                             input logic [31:0] exp);
        logic [31:0] d;
        csr_rd(use_b, idx, d);
        check(tag, d, exp);
    endtask

    task automatic wait_req(input string tag, input bit use_b);
        for (int i = 0; i < 8; i++) begin
            if (use_b ? bus_b.irq_req : bus_a.irq_req) break;
            step();
        end
        check(tag, 32'(use_b ? bus_b.irq_req : bus_a.irq_req), 32'd1);
    endtask

    task automatic ack(input logic [31:0] pc);
        bus_a.irq_ack = 1'b1;
        bus_a.irq_pc  = pc;
        step();
        bus_a.irq_ack = 1'b0;
    endtask

    task automatic exception(input logic [4:0] code, input logic [31:0] pc,
                             input logic [31:0] tval, input logic with_mret);
        bus_a.exc_valid = 1'b1;
        bus_a.exc_code  = code;
        bus_a.exc_pc    = pc;
        bus_a.exc_tval  = tval;
        bus_a.mret      = with_mret;
        step();
        bus_a.exc_valid = 1'b0;
        bus_a.mret      = 1'b0;
    endtask

    initial begin
        bus_a.sel = 1'b0; bus_a.idx = '0; bus_a.wdata = '0;
        bus_a.write = 1'b0; bus_a.set = 1'b0; bus_a.clear = 1'b0;
        bus_a.irq_ext = 1'b0; bus_a.irq_timer = 1'b0; bus_a.irq_soft = 1'b0;
        bus_a.irq_local = 1'b0; bus_a.irq_pc = '0; bus_a.irq_ack = 1'b0;
        bus_a.exc_valid = 1'b0; bus_a.exc_code = '0; bus_a.exc_pc = '0;
        bus_a.exc_tval = '0; bus_a.mret = 1'b0;

        // Reset state
        step(); step();
        reset = 1'b0;
        check_csr("rst_mstatus", 0, 8'h00, 32'h0000_1800);
        check_csr("rst_misa", 0, 8'h01, 32'h4000_0104);
        check_csr("rst_misa_b", 1, 8'h01, 32'h4000_0100);
        check_csr("rst_mie", 0, 8'h04, 32'h0);
        check_csr("rst_mtvec", 0, 8'h05, 32'h0);
        check_csr("rst_mscratch", 0, 8'h40, 32'h0);
        check_csr("rst_mepc", 0, 8'h41, 32'h0);
        check_csr("rst_mcause", 0, 8'h42, 32'h0);
        check_csr("rst_mtval", 0, 8'h43, 32'h0);
        check_csr("rst_mip", 0, 8'h44, 32'h0);
        check_csr("unmapped", 0, 8'h10, 32'h0);
        check("rst_irq_req", 32'(bus_a.irq_req), 32'd0);
        check("rst_trap_valid", 32'(bus_a.trap_valid), 32'd0);

        // Vectored timer interrupt; source drops before ack
        csr_op(8'h05, 32'h8000_0001, OP_WR);
        csr_op(8'h04, 32'hFFFF_FFFF, OP_WR);
        check_csr("mie_mask", 0, 8'h04, 32'h0000_0888);
        csr_op(8'h04, 32'h0000_0080, OP_WR);
        csr_op(8'h00, 32'h0000_0008, OP_SET);
        check_csr("mstatus_mie_set", 0, 8'h00, 32'h0000_1808);
        bus_a.irq_timer = 1'b1;
        check_csr("mip_timer", 0, 8'h44, 32'h0000_0080);
        wait_req("req_timer", 0);
        bus_a.irq_timer = 1'b0;
        step();
        check("req_hold", 32'(bus_a.irq_req), 32'd1);
        ack(32'h0000_0100);
        check("tv_timer", 32'(bus_a.trap_valid), 32'd1);
        check("tpc_timer", bus_a.trap_pc, 32'h8000_001C);
        check("req_drop_ack", 32'(bus_a.irq_req), 32'd0);
        check_csr("mepc_timer", 0, 8'h41, 32'h0000_0100);
        check_csr("mcause_timer", 0, 8'h42, 32'h8000_0007);
        check_csr("mstatus_timer", 0, 8'h00, 32'h0000_1880);
        step();
        check("tv_one_cycle", 32'(bus_a.trap_valid), 32'd0);

        // Priority ext > soft > timer, then mret re-enables
        csr_op(8'h04, 32'h0000_0888, OP_WR);
        bus_a.irq_ext = 1'b1; bus_a.irq_soft = 1'b1; bus_a.irq_timer = 1'b1;
        csr_op(8'h00, 32'h0000_0008, OP_SET);
        wait_req("req_ext", 0);
        ack(32'h0000_0200);
        check_csr("mcause_ext", 0, 8'h42, 32'h8000_000B);
        check("tpc_ext", bus_a.trap_pc, 32'h8000_002C);
        bus_a.irq_ext = 1'b0;
        bus_a.mret = 1'b1;
        step();
        bus_a.mret = 1'b0;
        check_csr("mstatus_mret", 0, 8'h00, 32'h0000_1888);
        wait_req("req_soft", 0);
        ack(32'h0000_0300);
        check_csr("mcause_soft", 0, 8'h42, 32'h8000_0003);
        check("tpc_soft", bus_a.trap_pc, 32'h8000_000C);
        check("ret_addr", bus_a.ret_addr, 32'h0000_0300);

        // Exception preempts a pending request
        csr_op(8'h00, 32'h0000_0008, OP_SET);
        wait_req("req_pre_exc", 0);
        exception(5'd2, 32'h0000_0400, 32'h0000_DEAD, 1'b0);
        check("tv_exc", 32'(bus_a.trap_valid), 32'd1);
        check("req_drop_exc", 32'(bus_a.irq_req), 32'd0);
        check("tpc_exc", bus_a.trap_pc, 32'h8000_0000);
        check_csr("mcause_exc", 0, 8'h42, 32'h0000_0002);
        check_csr("mtval_exc", 0, 8'h43, 32'h0000_DEAD);
        check_csr("mepc_exc", 0, 8'h41, 32'h0000_0400);
        check_csr("mstatus_exc", 0, 8'h00, 32'h0000_1880);
        bus_a.irq_soft = 1'b0; bus_a.irq_timer = 1'b0;

        // Exception and mret together: exception wins
        csr_op(8'h00, 32'h0000_0080, OP_WR);
        exception(5'd5, 32'h0000_0500, 32'h0000_0055, 1'b1);
        check_csr("mstatus_exc_mret", 0, 8'h00, 32'h0000_1800);
        check_csr("mcause_exc_mret", 0, 8'h42, 32'h0000_0005);

        // Exception and mcause write in the same cycle: trap wins
        bus_a.sel = 1'b1; bus_a.idx = 8'h42; bus_a.wdata = 32'h0000_AAAA; bus_a.write = 1'b1;
        exception(5'd7, 32'h0000_0700, 32'h0, 1'b0);
        bus_a.sel = 1'b0; bus_a.write = 1'b0;
        check_csr("mcause_exc_wr", 0, 8'h42, 32'h0000_0007);

        // Set/clear operations and mepc alignment with C
        csr_op(8'h40, 32'h1234_5678, OP_WR);
        csr_op(8'h40, 32'h0000_000F, OP_SET);
        csr_op(8'h40, 32'h0000_0030, OP_CLR);
        check_csr("mscratch_setclr", 0, 8'h40, 32'h1234_564F);

        // Direct mode: interrupts go to base
        csr_op(8'h05, 32'h0000_0040, OP_WR);
        csr_op(8'h00, 32'h0000_0008, OP_SET);
        bus_a.irq_timer = 1'b1;
        wait_req("req_direct", 0);
        ack(32'h0000_0800);
        check("tpc_direct", bus_a.trap_pc, 32'h0000_0040);
        bus_a.irq_timer = 1'b0;

        // Reset while a request is pending
        csr_op(8'h00, 32'h0000_0008, OP_SET);
        bus_a.irq_timer = 1'b1;
        wait_req("req_pre_rst", 0);
        reset = 1'b1;
        step();
        check("rst_req_drop", 32'(bus_a.irq_req), 32'd0);
        check("rst_no_trap", 32'(bus_a.trap_valid), 32'd0);
        reset = 1'b0;
        bus_a.irq_timer = 1'b0;
        check_csr("rst_mcause2", 0, 8'h42, 32'h0);

        // mepc alignment: C on dut_a, no C on dut_b
        csr_op(8'h41, 32'h0000_0123, OP_WR);
        check_csr("mepc_c", 0, 8'h41, 32'h0000_0122);
        check_csr("mepc_noc", 1, 8'h41, 32'h0000_0120);

        // Illegal MODE keeps the old MODE
        csr_op(8'h05, 32'h0000_0101, OP_WR);
        check_csr("mtvec_vec", 1, 8'h05, 32'h0000_0101);
        csr_op(8'h05, 32'h0000_0203, OP_WR);
        check_csr("mtvec_warl", 1, 8'h05, 32'h0000_0201);

        // Local interrupts on dut_b: lower index wins, vectored to 16
        csr_op(8'h04, 32'hFFFF_FFFF, OP_WR);
        check_csr("mie_mask_b", 1, 8'h04, 32'h0003_0888);
        csr_op(8'h04, 32'h0003_0000, OP_WR);
        check_csr("mie_local_a", 0, 8'h04, 32'h0);
        csr_op(8'h00, 32'h0000_0008, OP_SET);
        irq_local_b = 2'b11;
        check_csr("mip_local", 1, 8'h44, 32'h0003_0000);
        wait_req("req_local", 1);
        check("req_local_a", 32'(bus_a.irq_req), 32'd0);
        ack(32'h0000_0900);
        check("tv_local", 32'(bus_b.trap_valid), 32'd1);
        check("tpc_local", bus_b.trap_pc, 32'h0000_0240);
        check_csr("mcause_local", 1, 8'h42, 32'h8000_0010);
        check_csr("mepc_local", 1, 8'h41, 32'h0000_0900);
        irq_local_b = 2'b00;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
